// File: rtl/table_load_sequencer.sv
// Streams one header-described payload into NUM_TABLES config tables, then the inbound buffer.
// Optional abort/err handshake is compiled in with `define LOADER_ABORT_EN.
module table_load_sequencer #(
  parameter int NUM_TABLES = 9,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     num_entry_cfg_i,
  input  logic [ADDR_W-1:0]     num_entry_inb_i,
  input  logic [DATA_W-1:0]     s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [DATA_W-1:0]     wr_data_o,
  output logic [NUM_TABLES-1:0] wr_en_o,
  output logic [ADDR_W-1:0]     wr_addr_inb_o,
  output logic                  wr_en_inb_o,
  output logic                  busy_o,
`ifdef LOADER_ABORT_EN
  input  logic                  abort_i,
  output logic                  err_o,
`endif
  output logic                  done_o
);

  // state  | meaning
  // S_IDLE | waiting for start, counts not yet latched
  // S_CFG  | loading table tbl_q at addr_q
  // S_INB  | loading inbound buffer at addr_inb_q
  // S_DONE | one-cycle completion, done_o high
  typedef enum logic [1:0] {S_IDLE, S_CFG, S_INB, S_DONE} state_e;

  localparam int TBL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam logic [TBL_W-1:0] LAST_TBL = TBL_W'(NUM_TABLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cfg_q, cfg_d;
  logic [ADDR_W-1:0]     inb_q, inb_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [TBL_W-1:0]      tbl_q, tbl_d;
  logic [ADDR_W-1:0]     addr_inb_q, addr_inb_d;
  logic [NUM_TABLES-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  wr_en_inb_q, wr_en_inb_d;
  logic [ADDR_W-1:0]     wr_addr_inb_q, wr_addr_inb_d;
  logic [NUM_TABLES-1:0] tbl_hot;
  logic                  abort_w;
  logic                  xfer;

`ifdef LOADER_ABORT_EN
  logic err_q, err_d;
  assign abort_w = abort_i;
  assign err_d   = abort_i & ((state_q == S_CFG) | (state_q == S_INB));
  assign err_o   = err_q;
`else
  assign abort_w = 1'b0;
`endif

  assign s_ready_o = (state_q == S_CFG) | (state_q == S_INB);
  // The beat offered in an abort cycle is dropped even though s_ready_o is high.
  assign xfer      = s_valid_i & s_ready_o & ~abort_w;

  always_comb begin
    tbl_hot = '0;
    for (int i = 0; i < NUM_TABLES; i++) tbl_hot[i] = (tbl_q == TBL_W'(i));
  end

  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    inb_d         = inb_q;
    addr_d        = addr_q;
    tbl_d         = tbl_q;
    addr_inb_d    = addr_inb_q;
    wr_en_d       = '0;
    wr_en_inb_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_addr_inb_d = wr_addr_inb_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_d      = num_entry_cfg_i;
          inb_d      = num_entry_inb_i;
          addr_d     = '0;
          tbl_d      = '0;
          addr_inb_d = '0;
          if (num_entry_cfg_i != '0)      state_d = S_CFG;
          else if (num_entry_inb_i != '0) state_d = S_INB;
          else                            state_d = S_DONE;
        end
      end
      S_CFG: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wr_en_d   = tbl_hot;
          wr_addr_d = addr_q;
          wr_data_d = s_data_i;
          if (addr_q == cfg_q - ADDR_W'(1)) begin
            addr_d = '0;
            if (tbl_q == LAST_TBL) begin
              tbl_d   = '0;
              state_d = (inb_q != '0) ? S_INB : S_DONE;
            end else begin
              tbl_d = tbl_q + TBL_W'(1);
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_INB: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wr_en_inb_d   = 1'b1;
          wr_addr_inb_d = addr_inb_q;
          wr_data_d     = s_data_i;
          if (addr_inb_q == inb_q - ADDR_W'(1)) begin
            addr_inb_d = '0;
            state_d    = S_DONE;
          end else begin
            addr_inb_d = addr_inb_q + ADDR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cfg_q         <= '0;
      inb_q         <= '0;
      addr_q        <= '0;
      tbl_q         <= '0;
      addr_inb_q    <= '0;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_inb_q   <= 1'b0;
      wr_addr_inb_q <= '0;
`ifdef LOADER_ABORT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      inb_q         <= inb_d;
      addr_q        <= addr_d;
      tbl_q         <= tbl_d;
      addr_inb_q    <= addr_inb_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_inb_q   <= wr_en_inb_d;
      wr_addr_inb_q <= wr_addr_inb_d;
`ifdef LOADER_ABORT_EN
      err_q         <= err_d;
`endif
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign wr_en_inb_o   = wr_en_inb_q;
  assign wr_addr_inb_o = wr_addr_inb_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule
